kgp_mc_controller: RTL

- Multi-cycle control FSM that sequences the KGP-RISC datapath: fetch, decode, execute, memory access and write-back.
- Drives the datapath control strobes: PC/IR enables, ALU op/src, mem read/write, mem-to-reg, reg write, branch, branch-link.
- Handles variable-latency instruction and data memories via req/ack handshakes, with a wait-state timeout.

---
 rtl/kgp_mc_controller.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/kgp_mc_controller.sv
// Multi-cycle control FSM for the KGP-RISC datapath (fetch/decode/exec/mem/wb).
// Define KGP_PERF_CNT_EN to add the cyc_cnt/instr_cnt performance counters.
module kgp_mc_controller #(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  opcode,
    input  logic [4:0]  funct,
    input  logic        zero_flag,
    input  logic        neg_flag,
    input  logic        carry_flag,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        ir_en,
    output logic        pc_en,
    output logic [4:0]  alu_op,
    output logic        alu_src,
    output logic        branch,
    output logic        br_link,
    output logic        dmem_req,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        halted,
    output logic        bus_err,
    output logic        illegal,
    output logic [2:0]  state
`ifdef KGP_PERF_CNT_EN
    ,
    output logic [31:0] cyc_cnt,
    output logic [31:0] instr_cnt
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd7;

    localparam logic [5:0] OP_ALU  = 6'd0;
    localparam logic [5:0] OP_ALUI = 6'd1;
    localparam logic [5:0] OP_LW   = 6'd2;
    localparam logic [5:0] OP_SW   = 6'd3;
    localparam logic [5:0] OP_BCC  = 6'd4;
    localparam logic [5:0] OP_B    = 6'd5;
    localparam logic [5:0] OP_BL   = 6'd6;
    localparam logic [5:0] OP_BR   = 6'd7;
    localparam logic [5:0] OP_HALT = 6'd63;

    localparam logic [CNT_W:0]   WAIT_LIMIT = WAIT_MAX[CNT_W:0];
    localparam logic [CNT_W:0]   ONE_WIDE   = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ALL1   = {CNT_W{1'b1}};

    logic [2:0]       cur_state;
    logic [2:0]       next_state;
    logic [5:0]       op_q;
    logic [4:0]       funct_q;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W:0]   wait_inc;
    logic             wait_expired;
    logic             waiting;
    logic             set_bus_err;
    logic             set_illegal;
    logic             branch_taken;
    logic             opcode_legal;

    assign state    = cur_state;
    assign wait_inc = {1'b0, wait_cnt} + ONE_WIDE;
    // The request cycle that would bring the counter up to WAIT_MAX is the last one allowed.
    assign wait_expired = (WAIT_MAX != 0) && (wait_inc == WAIT_LIMIT);
    assign waiting = ((cur_state == S_FETCH) && !imem_ack) ||
                     ((cur_state == S_MEM) && !dmem_ack);
    assign opcode_legal = (opcode <= OP_BR);

    always_comb begin
        branch_taken = 1'b0;
        if (funct_q[4:2] == 3'b000) begin
            case (funct_q[1:0])
                2'd0:    branch_taken = zero_flag;
                2'd1:    branch_taken = !zero_flag;
                2'd2:    branch_taken = neg_flag;
                default: branch_taken = carry_flag;
            endcase
        end
    end

    always_comb begin
        next_state  = cur_state;
        imem_req    = 1'b0;
        ir_en       = 1'b0;
        pc_en       = 1'b0;
        alu_op      = 5'd0;
        alu_src     = 1'b0;
        branch      = 1'b0;
        br_link     = 1'b0;
        dmem_req    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        halted      = 1'b0;
        set_bus_err = 1'b0;
        set_illegal = 1'b0;
        case (cur_state)
            S_IDLE: begin
                if (start) next_state = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_en      = 1'b1;
                    pc_en      = 1'b1;
                    next_state = S_DECODE;
                end else if (wait_expired) begin
                    set_bus_err = 1'b1;
                    next_state  = S_HALT;
                end
            end
            S_DECODE: begin
                if (opcode == OP_HALT) begin
                    next_state = S_HALT;
                end else if (opcode_legal) begin
                    next_state = S_EXEC;
                end else begin
                    set_illegal = 1'b1;
                    next_state  = S_HALT;
                end
            end
            S_EXEC: begin
                next_state = S_FETCH;
                case (op_q)
                    OP_ALU: begin
                        alu_op     = funct_q;
                        next_state = S_WB;
                    end
                    OP_ALUI: begin
                        alu_op     = funct_q;
                        alu_src    = 1'b1;
                        next_state = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src    = 1'b1;
                        next_state = S_MEM;
                    end
                    OP_BCC: begin
                        branch = branch_taken;
                        pc_en  = branch_taken;
                    end
                    OP_B: begin
                        branch = 1'b1;
                        pc_en  = 1'b1;
                    end
                    OP_BL: begin
                        branch    = 1'b1;
                        pc_en     = 1'b1;
                        br_link   = 1'b1;
                        reg_write = 1'b1;
                    end
                    OP_BR: begin
                        branch = 1'b1;
                        pc_en  = 1'b1;
                        alu_op = 5'd31;
                    end
                    default: next_state = S_FETCH;
                endcase
            end
            S_MEM: begin
                dmem_req  = 1'b1;
                mem_read  = (op_q == OP_LW);
                mem_write = (op_q == OP_SW);
                if (dmem_ack) begin
                    next_state = (op_q == OP_LW) ? S_WB : S_FETCH;
                end else if (wait_expired) begin
                    set_bus_err = 1'b1;
                    next_state  = S_HALT;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (op_q == OP_LW);
                next_state = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state <= S_IDLE;
            op_q      <= 6'd0;
            funct_q   <= 5'd0;
            bus_err   <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            cur_state <= next_state;
            if (cur_state == S_DECODE) begin
                op_q    <= opcode;
                funct_q <= funct;
            end
            if (set_bus_err) bus_err <= 1'b1;
            if (set_illegal) illegal <= 1'b1;
        end
    end

    // Counter runs only while a request is outstanding; any other cycle clears it,
    // so it always starts from zero on entry to FETCH or MEM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (waiting) begin
            if (wait_cnt != CNT_ALL1) wait_cnt <= wait_inc[CNT_W-1:0];
        end else begin
            wait_cnt <= '0;
        end
    end

`ifdef KGP_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt   <= 32'd0;
            instr_cnt <= 32'd0;
        end else begin
            if ((cur_state != S_IDLE) && (cur_state != S_HALT)) cyc_cnt <= cyc_cnt + 32'd1;
            if ((next_state == S_FETCH) &&
                ((cur_state == S_EXEC) || (cur_state == S_MEM) || (cur_state == S_WB)))
                instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

endmodule
